// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and codes for the decode-stage hazard scoreboard.
// Slot entries carry a fixed-width address so one struct serves every NREG.
`timescale 1ns/1ps
package hazard_pkg;

  localparam int SEL_RF       = 0;
  localparam int SEL_STALL    = 1;
  localparam int SEL_FWD_BASE = 2;

  localparam int ADR_MAX_W = 16;

  typedef struct packed {
    logic                 valid;
    logic [ADR_MAX_W-1:0] adr;
    logic                 load;
  } slot_t;

  function automatic int cw_width(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_lookup.sv
// Priority match of one register against the in-flight slot array.
// The lowest-index (youngest) valid match decides the returned code.
`timescale 1ns/1ps
module sb_lookup
  import hazard_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int NREG       = 8,
  parameter int LOAD_READY = 2,
  parameter int CW         = 3
) (
  input  slot_t [DEPTH-1:0]     slots,
  input  logic                  use_en,
  input  logic [ADR_MAX_W-1:0]  adr,
  output logic [CW-1:0]         code
);

  logic in_range;

  assign in_range = (adr < ADR_MAX_W'(NREG));

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    code = CW'(SEL_RF);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (slots[i].valid && (slots[i].adr == adr)) begin
        if (slots[i].load && (i < LOAD_READY)) begin
          code = CW'(SEL_STALL);
        end else begin
          code = CW'(i + SEL_FWD_BASE);
        end
      end
    end
    if (!use_en || !in_range) begin
      code = CW'(SEL_RF);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight writes per post-decode
// stage and returns stall / forwarding-source codes per source operand.
`timescale 1ns/1ps
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int NREG       = 8,
  parameter  int DEPTH      = 3,
  parameter  int NRD        = 2,
  parameter  int LOAD_READY = 2,
  parameter  int CNTW       = 16,
  localparam int AW         = $clog2(NREG),
  localparam int CW         = cw_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_adr,
  input  logic              issue_load,
  input  logic [DEPTH-1:0]  flush_mask,
  input  logic [NRD-1:0]    rd_use,
  input  logic [NRD*AW-1:0] rd_adr,
  output logic [NRD*CW-1:0] rd_sel,
  output logic              hazard,
  output logic [NREG*CW-1:0] reg_status,
  input  logic              cnt_clear,
  output logic [CNTW-1:0]   stall_count
);

  logic [DEPTH-1:0] slot_vld;
  logic [AW-1:0]    slot_adr [DEPTH];
  logic [DEPTH-1:0] slot_load;
  slot_t [DEPTH-1:0] slots;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  // Stage boundary: ID -> EX .. WB slot advance (valid is the only reset state)
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_vld <= '0;
    end else if (hold) begin
      slot_vld <= slot_vld & ~flush_mask;
    end else begin
      slot_vld[0] <= issue_valid & ~flush_mask[0];
      for (int i = 1; i < DEPTH; i++) begin
        slot_vld[i] <= slot_vld[i-1] & ~flush_mask[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!hold) begin
      slot_adr[0]  <= issue_adr;
      slot_load[0] <= issue_load;
      for (int i = 1; i < DEPTH; i++) begin
        slot_adr[i]  <= slot_adr[i-1];
        slot_load[i] <= slot_load[i-1];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slots[i].valid = slot_vld[i];
      slots[i].adr   = ADR_MAX_W'(slot_adr[i]);
      slots[i].load  = slot_load[i];
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    sb_lookup #(
      .DEPTH      (DEPTH),
      .NREG       (NREG),
      .LOAD_READY (LOAD_READY),
      .CW         (CW)
    ) u_lookup (
      .slots  (slots),
      .use_en (rd_use[j]),
      .adr    (ADR_MAX_W'(rd_adr[j*AW +: AW])),
      .code   (rd_sel[j*CW +: CW])
    );
  end

  for (genvar r = 0; r < NREG; r++) begin : g_status
    sb_lookup #(
      .DEPTH      (DEPTH),
      .NREG       (NREG),
      .LOAD_READY (LOAD_READY),
      .CW         (CW)
    ) u_lookup (
      .slots  (slots),
      .use_en (1'b1),
      .adr    (ADR_MAX_W'(r)),
      .code   (reg_status[r*CW +: CW])
    );
  end

  always_comb begin
    hazard = 1'b0;
    for (int j = 0; j < NRD; j++) begin
      if (rd_use[j] && (rd_sel[j*CW +: CW] == CW'(SEL_STALL))) begin
        hazard = 1'b1;
      end
    end
  end

  // Stall counter: clear wins over the saturating increment
  always_ff @(posedge clk) begin
    if (reset || cnt_clear) begin
      stall_count <= '0;
    end else if (hazard) begin
      stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random
// stimulus checked against an in-flight-write reference model.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

  localparam int NREG       = 8;
  localparam int DEPTH      = 3;
  localparam int NRD        = 2;
  localparam int LOAD_READY = 2;
  localparam int CNTW       = 4;
  localparam int AW         = 3;
  localparam int CW         = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              hold;
  logic              issue_valid;
  logic [AW-1:0]     issue_adr;
  logic              issue_load;
  logic [DEPTH-1:0]  flush_mask;
  logic [NRD-1:0]    rd_use;
  logic [NRD*AW-1:0] rd_adr;
  logic [NRD*CW-1:0] rd_sel;
  logic              hazard;
  logic [NREG*CW-1:0] reg_status;
  logic              cnt_clear;
  logic [CNTW-1:0]   stall_count;

  int checks   = 0;
  int failures = 0;

  bit m_v [DEPTH];
  int m_a [DEPTH];
  bit m_l [DEPTH];
  int m_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NREG       (NREG),
    .DEPTH      (DEPTH),
    .NRD        (NRD),
    .LOAD_READY (LOAD_READY),
    .CNTW       (CNTW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hold        (hold),
    .issue_valid (issue_valid),
    .issue_adr   (issue_adr),
    .issue_load  (issue_load),
    .flush_mask  (flush_mask),
    .rd_use      (rd_use),
    .rd_adr      (rd_adr),
    .rd_sel      (rd_sel),
    .hazard      (hazard),
    .reg_status  (reg_status),
    .cnt_clear   (cnt_clear),
    .stall_count (stall_count)
  );

  function automatic int m_lookup(input int r);
    for (int i = 0; i < DEPTH; i++) begin
      if (m_v[i] && m_a[i] == r) return (m_l[i] && i < LOAD_READY) ? 1 : i + 2;
    end
    return 0;
  endfunction

  function automatic bit m_hazard();
    for (int j = 0; j < NRD; j++) begin
      if (rd_use[j] && m_lookup(int'(rd_adr[j*AW +: AW])) == 1) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int sel_of(input int j);
    return int'(rd_sel[j*CW +: CW]);
  endfunction

  function automatic int status_of(input int r);
    return int'(reg_status[r*CW +: CW]);
  endfunction

  task automatic idle();
    reset = 1'b0; hold = 1'b0; issue_valid = 1'b0; issue_adr = '0; issue_load = 1'b0;
    flush_mask = '0; rd_use = '0; rd_adr = '0; cnt_clear = 1'b0;
  endtask

  // Advances one clock edge, updating the model from the inputs seen at that edge.
  task automatic cycle();
    bit nv [DEPTH];
    int na [DEPTH];
    bit nl [DEPTH];
    int nc;
    bit hz;
    hz = m_hazard();
    nv = m_v; na = m_a; nl = m_l; nc = m_cnt;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) nv[i] = 1'b0;
      nc = 0;
    end else begin
      if (hold) begin
        for (int i = 0; i < DEPTH; i++) nv[i] = m_v[i] && !flush_mask[i];
      end else begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          nv[i] = m_v[i-1] && !flush_mask[i]; na[i] = m_a[i-1]; nl[i] = m_l[i-1];
        end
        nv[0] = issue_valid && !flush_mask[0]; na[0] = int'(issue_adr); nl[0] = issue_load;
      end
      if (cnt_clear) nc = 0;
      else if (hz && m_cnt < (1 << CNTW) - 1) nc = m_cnt + 1;
    end
    @(posedge clk);
    #1;
    m_v = nv; m_a = na; m_l = nl; m_cnt = nc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle(); do_reset();
    rd_use = 2'b11; rd_adr = {3'd2, 3'd1};
    for (int k = 0; k < 3; k++) begin
      issue_valid = 1'b1; issue_adr = 3'(k + 1); issue_load = 1'b1;
      cycle();
    end
    #1;
    checks++;
    if (stall_count !== 4'd2) begin
      failures++; $display("FAIL reset_precount: got %0d want 2", stall_count);
    end
    reset = 1'b1; hold = 1'b1; issue_valid = 1'b1;
    cycle();
    #1;
    checks++;
    if (reg_status !== '0) begin
      failures++; $display("FAIL reset_status: got %h want 0", reg_status);
    end
    checks++;
    if (hazard !== 1'b0 || rd_sel !== '0) begin
      failures++; $display("FAIL reset_sel: hazard %b rd_sel %h want 0/0", hazard, rd_sel);
    end
    checks++;
    if (stall_count !== '0) begin
      failures++; $display("FAIL reset_count: got %0d want 0", stall_count);
    end
    idle();
  endtask

  task automatic test_forward();
    int exp_code [4] = '{2, 3, 4, 0};
    idle(); do_reset();
    issue_valid = 1'b1; issue_adr = 3'd3; issue_load = 1'b0;
    rd_use = 2'b01; rd_adr = {3'd0, 3'd3};
    #1;
    checks++;
    if (sel_of(0) !== 0) begin
      failures++; $display("FAIL fwd_same_cycle: got %0d want 0", sel_of(0));
    end
    cycle();
    issue_valid = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (sel_of(0) !== exp_code[k] || hazard !== 1'b0) begin
        failures++;
        $display("FAIL fwd_step%0d: sel %0d hazard %b want %0d/0", k, sel_of(0), hazard, exp_code[k]);
      end
      cycle();
      #1;
    end
  endtask

  task automatic test_load_use();
    int exp_code [3] = '{1, 1, 4};
    idle(); do_reset();
    issue_valid = 1'b1; issue_adr = 3'd5; issue_load = 1'b1;
    cycle();
    issue_valid = 1'b0; rd_use = 2'b01; rd_adr = {3'd0, 3'd5};
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (sel_of(0) !== exp_code[k] || hazard !== (exp_code[k] == 1)) begin
        failures++;
        $display("FAIL load_use_step%0d: sel %0d hazard %b want %0d", k, sel_of(0), hazard, exp_code[k]);
      end
      if (k < 2) begin
        cycle();
        #1;
      end
    end
    checks++;
    if (stall_count !== 4'd2) begin
      failures++; $display("FAIL load_use_count: got %0d want 2", stall_count);
    end
  endtask

  task automatic test_youngest();
    idle(); do_reset();
    issue_valid = 1'b1; issue_adr = 3'd2; issue_load = 1'b0;
    cycle();
    cycle();
    issue_valid = 1'b0; rd_use = 2'b01; rd_adr = {3'd0, 3'd2};
    #1;
    checks++;
    if (sel_of(0) !== 2) begin
      failures++; $display("FAIL youngest: got %0d want 2", sel_of(0));
    end
    flush_mask = 3'b010;
    cycle();
    flush_mask = '0;
    #1;
    checks++;
    if (sel_of(0) !== 4 || status_of(2) !== 4) begin
      failures++; $display("FAIL youngest_flush: sel %0d status %0d want 4", sel_of(0), status_of(2));
    end
  endtask

  task automatic test_hold();
    idle(); do_reset();
    issue_valid = 1'b1; issue_adr = 3'd1; issue_load = 1'b1;
    cycle();
    issue_valid = 1'b0; hold = 1'b1; rd_use = 2'b01; rd_adr = {3'd0, 3'd1};
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (sel_of(0) !== 1 || hazard !== 1'b1) begin
        failures++; $display("FAIL hold_step%0d: sel %0d hazard %b want 1/1", k, sel_of(0), hazard);
      end
      if (k < 3) begin
        issue_valid = 1'b1; issue_adr = 3'd6;
        cycle();
        issue_valid = 1'b0;
      end
    end
    checks++;
    if (stall_count !== 4'd3 || status_of(6) !== 0) begin
      failures++; $display("FAIL hold_count: count %0d r6 %0d want 3/0", stall_count, status_of(6));
    end
    flush_mask = 3'b001;
    cycle();
    flush_mask = '0;
    #1;
    checks++;
    if (sel_of(0) !== 0 || hazard !== 1'b0 || stall_count !== 4'd4) begin
      failures++;
      $display("FAIL hold_flush: sel %0d hazard %b count %0d want 0/0/4", sel_of(0), hazard, stall_count);
    end
    idle();
  endtask

  task automatic test_saturation();
    idle(); do_reset();
    issue_valid = 1'b1; issue_adr = 3'd4; issue_load = 1'b1;
    cycle();
    issue_valid = 1'b0; hold = 1'b1; rd_use = 2'b10; rd_adr = {3'd4, 3'd4};
    repeat (20) cycle();
    #1;
    checks++;
    if (stall_count !== 4'd15 || hazard !== 1'b1) begin
      failures++; $display("FAIL sat_count: count %0d hazard %b want 15/1", stall_count, hazard);
    end
    checks++;
    if (sel_of(1) !== 1 || sel_of(0) !== 0) begin
      failures++; $display("FAIL sat_use_gate: sel1 %0d sel0 %0d want 1/0", sel_of(1), sel_of(0));
    end
    cnt_clear = 1'b1;
    cycle();
    cnt_clear = 1'b0;
    #1;
    checks++;
    if (stall_count !== 4'd0) begin
      failures++; $display("FAIL sat_clear: got %0d want 0", stall_count);
    end
    cycle();
    #1;
    checks++;
    if (stall_count !== 4'd1) begin
      failures++; $display("FAIL sat_after_clear: got %0d want 1", stall_count);
    end
    idle();
  endtask

  task automatic test_random();
    idle(); do_reset();
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 49) == 0);
      hold        = ($urandom_range(0, 3) == 0);
      issue_valid = ($urandom_range(0, 9) < 6);
      issue_adr   = 3'($urandom);
      issue_load  = ($urandom_range(0, 9) < 4);
      flush_mask  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      cnt_clear   = ($urandom_range(0, 19) == 0);
      rd_use      = 2'($urandom);
      rd_adr      = 6'($urandom);
      #1;
      for (int j = 0; j < NRD; j++) begin
        int exp_sel;
        exp_sel = rd_use[j] ? m_lookup(int'(rd_adr[j*AW +: AW])) : 0;
        checks++;
        if (sel_of(j) !== exp_sel) begin
          failures++; $display("FAIL rnd_sel%0d cyc%0d: got %0d want %0d", j, n, sel_of(j), exp_sel);
        end
      end
      checks++;
      if (hazard !== m_hazard()) begin
        failures++; $display("FAIL rnd_hazard cyc%0d: got %b want %b", n, hazard, m_hazard());
      end
      checks++;
      if (int'(stall_count) !== m_cnt) begin
        failures++; $display("FAIL rnd_count cyc%0d: got %0d want %0d", n, stall_count, m_cnt);
      end
      for (int r = 0; r < NREG; r++) begin
        checks++;
        if (status_of(r) !== m_lookup(r)) begin
          failures++; $display("FAIL rnd_status r%0d cyc%0d: got %0d want %0d", r, n, status_of(r), m_lookup(r));
        end
      end
      cycle();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_v[i] = 1'b0; m_a[i] = 0; m_l[i] = 1'b0;
    end
    m_cnt = 0;
    idle();
    test_reset();
    test_forward();
    test_load_use();
    test_youngest();
    test_hold();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
